// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the EX stage and the multiply/divide sequencer.
// The EX stage drives through the master modport; the sequencer uses the slave modport.
interface muldiv_unit_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, funct, operand_1, operand_2, flush,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  start, funct, operand_1, operand_2, flush,
        output stall_req, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module muldiv_unit (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifndef MULDIV_FAST_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd1;
`endif
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] op_b;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_mult;
    logic        is_div;
    logic        is_signed;
    logic        div_zero;
    logic        iter_op;
    logic        last;
    logic [31:0] abs_1;
    logic [31:0] abs_2;

    assign is_mult   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
    assign is_div    = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
    assign is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    assign div_zero  = (bus.operand_2 == 32'd0);
    assign last      = (cnt == 6'd31);

    // 0x8000_0000 negates to itself, which read as unsigned is exactly its magnitude.
    assign abs_1 = (is_signed && bus.operand_1[31]) ? (~bus.operand_1 + 32'd1) : bus.operand_1;
    assign abs_2 = (is_signed && bus.operand_2[31]) ? (~bus.operand_2 + 32'd1) : bus.operand_2;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_1;
    logic [63:0] ext_2;
    logic [63:0] fast_prod;

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    assign ext_1     = is_signed ? {{32{bus.operand_1[31]}}, bus.operand_1} : {32'd0, bus.operand_1};
    assign ext_2     = is_signed ? {{32{bus.operand_2[31]}}, bus.operand_2} : {32'd0, bus.operand_2};
    assign fast_prod = ext_1 * ext_2;
    assign iter_op   = is_div && !div_zero;
`else
    logic [31:0] op_a;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod_fix;

    // Adding into the upper half then shifting right is the same as adding a left-shifted multiplicand.
    assign mul_sum  = {1'b0, acc[63:32]} + (op_b[0] ? {1'b0, op_a} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};
    assign prod_fix = neg_q ? (~mul_next + 64'd1) : mul_next;
    assign iter_op  = is_mult || (is_div && !div_zero);
`endif

    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // The shifted partial remainder needs 33 bits before the trial subtract.
    assign div_diff = {1'b0, acc[63:31]} - {2'b00, op_b};
    assign div_next = div_diff[33] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};
    assign quot_fix = neg_q ? (~div_next[31:0] + 32'd1)  : div_next[31:0];
    assign rem_fix  = neg_r ? (~div_next[63:32] + 32'd1) : div_next[63:32];

    assign bus.stall_req = !bus.flush &&
                           (((state == ST_IDLE) && bus.start && iter_op) ||
                            ((state != ST_IDLE) && !last));
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // NOTE: all state below is registered with non-blocking assignments so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            op_b   <= 32'd0;
`ifndef MULDIV_FAST_MUL_EN
            op_a   <= 32'd0;
`endif
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
                cnt   <= 6'd0;
            end else if (state == ST_IDLE) begin
                if (bus.start) begin
                    if (is_mult) begin
`ifdef MULDIV_FAST_MUL_EN
                        {hi_q, lo_q} <= fast_prod;
                        done_q       <= 1'b1;
`else
                        op_a  <= abs_1;
                        op_b  <= abs_2;
                        acc   <= 64'd0;
                        neg_q <= is_signed & (bus.operand_1[31] ^ bus.operand_2[31]);
                        neg_r <= 1'b0;
                        cnt   <= 6'd0;
                        state <= ST_MUL;
`endif
                    end else if (is_div && div_zero) begin
                        hi_q   <= bus.operand_1;
                        lo_q   <= 32'hFFFF_FFFF;
                        done_q <= 1'b1;
                    end else if (is_div) begin
                        op_b  <= abs_2;
                        acc   <= {32'd0, abs_1};
                        neg_q <= is_signed & (bus.operand_1[31] ^ bus.operand_2[31]);
                        neg_r <= is_signed & bus.operand_1[31];
                        cnt   <= 6'd0;
                        state <= ST_DIV;
                    end else if (bus.funct == FUNCT_MTHI) begin
                        hi_q <= bus.operand_1;
                    end else if (bus.funct == FUNCT_MTLO) begin
                        lo_q <= bus.operand_1;
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
            end else if (state == ST_MUL) begin
                acc  <= mul_next;
                op_b <= op_b >> 1;
                cnt  <= cnt + 6'd1;
                if (last) begin
                    {hi_q, lo_q} <= prod_fix;
                    done_q       <= 1'b1;
                    cnt          <= 6'd0;
                    state        <= ST_IDLE;
                end
`endif
            end else if (state == ST_DIV) begin
                acc <= div_next;
                cnt <= cnt + 6'd1;
                if (last) begin
                    hi_q   <= rem_fix;
                    lo_q   <= quot_fix;
                    done_q <= 1'b1;
                    cnt    <= 6'd0;
                    state  <= ST_IDLE;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// directed corner cases with literal results, then randomized back-to-back traffic.
module tb_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_NOP   = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if bus();

    muldiv_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic, independent of any shift/subtract sequencing.
    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    // Returns {remainder, quotient}; SV / and % truncate toward zero like the divider.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic bit is_iter(input logic [5:0] f, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
        return ((f == F_DIV) || (f == F_DIVU)) && (b != 32'd0);
`else
        return (f == F_MULT) || (f == F_MULTU) ||
               (((f == F_DIV) || (f == F_DIVU)) && (b != 32'd0));
`endif
    endfunction

    // Model state: phase counts remaining iteration cycles, 0 means idle.
    int          m_phase = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_done = 1'b0;
    logic [31:0] r_hi = 32'd0;
    logic [31:0] r_lo = 32'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_stall;
            logic [63:0] res;
            exp_stall = !bus.flush &&
                        (((m_phase == 0) && bus.start && is_iter(bus.funct, bus.operand_2)) ||
                         (m_phase > 1));
            check("stall_req", 64'(bus.stall_req), 64'(exp_stall));
            check("done", 64'(bus.done), 64'(m_done));
            check("hi", 64'(bus.hi), 64'(m_hi));
            check("lo", 64'(bus.lo), 64'(m_lo));

            if (rst) begin
                m_phase = 0;
                m_hi    = 32'd0;
                m_lo    = 32'd0;
                m_done  = 1'b0;
            end else begin
                m_done = 1'b0;
                if (bus.flush) begin
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    m_hi    = r_hi;
                    m_lo    = r_lo;
                    m_done  = 1'b1;
                    m_phase = 0;
                end else if (m_phase > 1) begin
                    m_phase--;
                end else if (bus.start) begin
                    case (bus.funct)
                        F_MULT, F_MULTU: begin
                            res = ref_mul(bus.funct == F_MULT, bus.operand_1, bus.operand_2);
`ifdef MULDIV_FAST_MUL_EN
                            {m_hi, m_lo} = res;
                            m_done = 1'b1;
`else
                            {r_hi, r_lo} = res;
                            m_phase = 32;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            if (bus.operand_2 == 32'd0) begin
                                m_hi   = bus.operand_1;
                                m_lo   = 32'hFFFF_FFFF;
                                m_done = 1'b1;
                            end else begin
                                {r_hi, r_lo} = ref_div(bus.funct == F_DIV, bus.operand_1, bus.operand_2);
                                m_phase = 32;
                            end
                        end
                        F_MTHI: m_hi = bus.operand_1;
                        F_MTLO: m_lo = bus.operand_1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Issues one operation; index 0 is the start cycle. Records stall length and first done.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int len, input int flush_at, input int rst_at,
                          output int stall_cnt, output int done_at);
        stall_cnt     = 0;
        done_at       = -1;
        bus.start     = 1'b1;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        for (int i = 0; i < len; i++) begin
            bus.flush = (i == flush_at);
            rst       = (i == rst_at);
            @(negedge clk);
            if (bus.stall_req) stall_cnt++;
            if (bus.done && (done_at < 0)) done_at = i;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.flush = 1'b0;
            rst       = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'(signed'(-($urandom_range(1, 20))));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int sc;
        int da;
        logic [5:0] ops [7];
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_NOP};

        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.funct     = 6'd0;
        bus.operand_1 = 32'd0;
        bus.operand_2 = 32'd0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);

        run_op(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 34, -1, -1, sc, da);
        check("mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFA);
`ifdef MULDIV_FAST_MUL_EN
        check("mult_stall_len", 64'(sc), 64'd0);
        check("mult_done_at", 64'(da), 64'd1);
`else
        check("mult_stall_len", 64'(sc), 64'd32);
        check("mult_done_at", 64'(da), 64'd33);
`endif

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, -1, -1, sc, da);
        check("multu_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);

        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 34, -1, -1, sc, da);
        check("div_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("div_stall_len", 64'(sc), 64'd32);
        check("div_done_at", 64'(da), 64'd33);

        run_op(F_DIVU, 32'd100, 32'd7, 34, -1, -1, sc, da);
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);

        run_op(F_DIVU, 32'h1234_5678, 32'd0, 2, -1, -1, sc, da);
        check("divz_stall_len", 64'(sc), 64'd0);
        check("divz_done_at", 64'(da), 64'd1);
        check("divz_hi", 64'(bus.hi), 64'h0000_0000_1234_5678);
        check("divz_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);

        run_op(F_MTHI, 32'hAAAA_AAAA, 32'd0, 1, -1, -1, sc, da);
        run_op(F_MTLO, 32'h5555_5555, 32'd0, 1, -1, -1, sc, da);
        check("mthi_hi", 64'(bus.hi), 64'h0000_0000_AAAA_AAAA);
        check("mtlo_lo", 64'(bus.lo), 64'h0000_0000_5555_5555);

`ifdef MULDIV_FAST_MUL_EN
        run_op(F_DIVU, 32'd5, 32'd7, 12, 10, -1, sc, da);
`else
        run_op(F_MULT, 32'd5, 32'd7, 12, 10, -1, sc, da);
`endif
        check("flush_stall_len", 64'(sc), 64'd10);
        check("flush_no_done", 64'(da), 64'(-1));
        check("flush_hi", 64'(bus.hi), 64'h0000_0000_AAAA_AAAA);
        check("flush_lo", 64'(bus.lo), 64'h0000_0000_5555_5555);

        run_op(F_DIVU, 32'd9, 32'd4, 34, -1, -1, sc, da);
        check("post_flush_lo", 64'(bus.lo), 64'd2);
        check("post_flush_hi", 64'(bus.hi), 64'd1);

        // The reset cycle itself still shows stall; it must be low the cycle after.
        run_op(F_DIV, 32'd100, 32'd3, 22, -1, 20, sc, da);
        check("rst_stall_len", 64'(sc), 64'd21);
        check("rst_no_done", 64'(da), 64'(-1));
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);

        // Back-to-back random traffic: next start lands in the cycle after return to idle.
        for (int n = 0; n < 250; n++) begin
            logic [5:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int          len;
            int          fl;
            f  = ops[$urandom_range(0, 6)];
            a  = rand_operand();
            b  = rand_operand();
            fl = -1;
            if (is_iter(f, b)) begin
                len = 33;
                if ($urandom_range(0, 7) == 0) begin
                    fl  = $urandom_range(0, 32);
                    len = fl + 1;
                end
            end else begin
                len = 1;
                if ($urandom_range(0, 7) == 0) fl = 0;
            end
            run_op(f, a, b, len, fl, -1, sc, da);
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
